seg_scan_decoder: RTL and testbench

- Observes a time-multiplexed 8-digit 7-segment scan bus: one-hot digit enable plus shared segment byte, as produced by our numeric screen driver.
- Reconstructs per-digit hex value, dot and blank state, and reports scan faults.
- Sits on the receive side: scan-bus checker in loopback self-test, and bench/monitor for screen logic.

---
 rtl/seg_scan_pkg.sv | 40 ++++
 rtl/seg7_inverse.sv | 29 ++
 rtl/seg_scan_decoder.sv | 135 +++++++++++++
 tb/tb_seg_scan_decoder.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg_scan_pkg.sv
// Shared types, glyph table and enable-decode helper for the 7-segment scan-bus decoder.
package seg_scan_pkg;

    typedef logic [7:0]      seg_t;
    typedef logic [7:0][3:0] digit_arr_t;

    typedef struct packed {
        logic [2:0] idx;
        logic       single;
        logic       multi;
        logic       none;
    } sel_t;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Active-high {g,f,e,d,c,b,a} encodings for hex digits 0..F.
    localparam logic [6:0] GLYPH [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    // sel is active-high; idx is only meaningful when single is set.
    function automatic sel_t onehot_idx(input logic [7:0] sel);
        sel_t r;
        int   n;
        r = '0;
        n = 0;
        for (int i = 0; i < 8; i++) begin
            if (sel[i]) begin
                n++;
                r.idx = 3'(i);
            end
        end
        r.none   = (n == 0);
        r.single = (n == 1);
        r.multi  = (n > 1);
        return r;
    endfunction

endpackage

// File: rtl/seg7_inverse.sv
// Combinational inverse of the seg7 encoder: active-low segment byte to hex value,
// blank and match flags, plus the lit state of the decimal point.
module seg7_inverse
    import seg_scan_pkg::*;
(
    input  seg_t       seg,
    output logic [3:0] value,
    output logic       blank,
    output logic       match,
    output logic       dp
);

    logic [6:0] lit;

    always_comb begin
        lit   = ~seg[6:0];
        value = 4'd0;
        match = 1'b0;
        blank = (seg[6:0] == SEG_BLANK);
        dp    = ~seg[7];
        for (int g = 0; g < 16; g++) begin
            if (lit == GLYPH[g]) begin
                value = 4'(g);
                match = 1'b1;
            end
        end
    end

endmodule

// File: rtl/seg_scan_decoder.sv
// Receive-side decoder for an 8-digit multiplexed 7-segment scan bus with fault pulses.
// Define SEG_SCAN_TIMEOUT_EN to drop a digit's valid after TIMEOUT_CYCLES without a commit.
module seg_scan_decoder
    import seg_scan_pkg::*;
#(
    parameter int STABLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 1048576
) (
    input  logic       clock,
    input  logic       rst,
    input  logic [7:0] scan_en,
    input  seg_t       scan_seg,
    output digit_arr_t digits,
    output logic [7:0] dots,
    output logic [7:0] blank,
    output logic [7:0] valid,
    output logic       frame_done,
    output logic       bad_pattern,
    output logic       multi_sel
);

    localparam logic [7:0] STABLE_N = 8'(STABLE_CYCLES);

    if (STABLE_CYCLES < 1 || STABLE_CYCLES > 255 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("seg_scan_decoder: STABLE_CYCLES or TIMEOUT_CYCLES out of range");
    end

    logic [7:0] en_p0, en_p1;
    seg_t       seg_p0, seg_p1;
    logic [7:0] stab_cnt, stab_cnt_nxt;
    logic       armed, armed_eff, changed;
    logic       eval_p0, act_p0;
    logic [7:0] seen;
    sel_t       sel;
    logic [3:0] g_value;
    logic       g_blank, g_match, g_dp;
    logic       commit, bad_nxt, multi_nxt;
    logic [7:0] commit_mask, valid_nxt;

    seg7_inverse u_inv (
        .seg   (seg_p0),
        .value (g_value),
        .blank (g_blank),
        .match (g_match),
        .dp    (g_dp)
    );

    // Stage p0 -> evaluate: stability filter and single-shot evaluation per selection window
    always_comb begin
        changed   = (en_p0 != en_p1) || (seg_p0 != seg_p1);
        armed_eff = changed || armed;
        if (changed)
            stab_cnt_nxt = 8'd1;
        else if (stab_cnt == STABLE_N)
            stab_cnt_nxt = stab_cnt;
        else
            stab_cnt_nxt = stab_cnt + 8'd1;
        eval_p0     = armed_eff && (stab_cnt_nxt == STABLE_N);
        sel         = onehot_idx(~en_p0);
        act_p0      = eval_p0 && !sel.none;
        commit      = act_p0 && sel.single && (g_match || g_blank);
        bad_nxt     = act_p0 && sel.single && !g_match && !g_blank;
        multi_nxt   = act_p0 && sel.multi;
        commit_mask = commit ? (8'd1 << sel.idx) : 8'd0;
    end

`ifdef SEG_SCAN_TIMEOUT_EN
    localparam int              TO_W   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT_CYCLES);

    logic [7:0][TO_W-1:0] to_cnt, to_cnt_nxt;
    logic [7:0]           stale;

    always_comb begin
        to_cnt_nxt = to_cnt;
        stale      = '0;
        for (int i = 0; i < 8; i++) begin
            if (commit_mask[i])
                to_cnt_nxt[i] = '0;
            else if (to_cnt[i] != TO_MAX)
                to_cnt_nxt[i] = to_cnt[i] + TO_W'(1);
            stale[i] = (to_cnt_nxt[i] == TO_MAX);
        end
        valid_nxt = (valid & ~stale) | commit_mask;
    end

    always_ff @(posedge clock or negedge rst) begin
        if (!rst)
            to_cnt <= '0;
        else
            to_cnt <= to_cnt_nxt;
    end
`else
    assign valid_nxt = valid | commit_mask;
`endif

    // Stage input -> p0 -> p1, and evaluate -> registered outputs
    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            en_p0       <= 8'hFF;
            seg_p0      <= 8'hFF;
            en_p1       <= 8'hFF;
            seg_p1      <= 8'hFF;
            stab_cnt    <= 8'd0;
            armed       <= 1'b1;
            seen        <= 8'h00;
            digits      <= '0;
            dots        <= 8'h00;
            blank       <= 8'h00;
            valid       <= 8'h00;
            frame_done  <= 1'b0;
            bad_pattern <= 1'b0;
            multi_sel   <= 1'b0;
        end else begin
            en_p0       <= scan_en;
            seg_p0      <= scan_seg;
            en_p1       <= en_p0;
            seg_p1      <= seg_p0;
            stab_cnt    <= stab_cnt_nxt;
            armed       <= eval_p0 ? 1'b0 : armed_eff;
            bad_pattern <= bad_nxt;
            multi_sel   <= multi_nxt;
            valid       <= valid_nxt;
            // A full mask is reported one cycle later and restarts empty, keeping any same-cycle commit.
            frame_done  <= (seen == 8'hFF);
            seen        <= ((seen == 8'hFF) ? 8'h00 : seen) | commit_mask;
            if (commit) begin
                digits[sel.idx] <= g_value;
                dots[sel.idx]   <= g_dp;
                blank[sel.idx]  <= g_blank;
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Self-checking bench for seg_scan_decoder: directed scenarios plus random scan traffic
// compared every cycle against a run-length reference model.
module tb_seg_scan_decoder;

    localparam int S  = 4;
    localparam int TO = 16;

    logic            clock = 1'b0;
    logic            rst   = 1'b0;
    logic [7:0]      scan_en  = 8'hFF;
    logic [7:0]      scan_seg = 8'hFF;
    logic [7:0][3:0] digits;
    logic [7:0]      dots, blank, valid;
    logic            frame_done, bad_pattern, multi_sel;

    always #5 clock = ~clock;

    seg_scan_decoder #(
        .STABLE_CYCLES  (S),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clock       (clock),
        .rst         (rst),
        .scan_en     (scan_en),
        .scan_seg    (scan_seg),
        .digits      (digits),
        .dots        (dots),
        .blank       (blank),
        .valid       (valid),
        .frame_done  (frame_done),
        .bad_pattern (bad_pattern),
        .multi_sel   (multi_sel)
    );

    logic [6:0] gl [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                            7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [7:0][3:0] e_digits;
    logic [7:0]      e_dots, e_blank, e_committed, e_seen;
    logic            e_frame, e_bad, e_multi;
    int              e_last [8];
    logic [15:0]     last_in;
    int              run;
    int              cyc;
    int              n_frame, n_bad, n_multi;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        e_digits    = '0;
        e_dots      = '0;
        e_blank     = '0;
        e_committed = '0;
        e_seen      = '0;
        e_frame     = 1'b0;
        e_bad       = 1'b0;
        e_multi     = 1'b0;
        for (int i = 0; i < 8; i++) e_last[i] = 0;
        last_in = 16'hFFFF;
        run     = 0;
    endtask

    // A value driven for S consecutive edges is evaluated on the following edge, once.
    task automatic model_edge(input logic [15:0] v);
        logic [7:0] en, cm;
        logic [6:0] lit;
        int         nlow, idx, gv;
        cyc++;
        cm      = '0;
        e_bad   = 1'b0;
        e_multi = 1'b0;
        if (run == S) begin
            en   = last_in[15:8];
            lit  = ~last_in[6:0];
            nlow = 0;
            idx  = 0;
            for (int i = 0; i < 8; i++) begin
                if (!en[i]) begin
                    nlow++;
                    idx = i;
                end
            end
            if (nlow > 1) begin
                e_multi = 1'b1;
            end else if (nlow == 1) begin
                gv = -1;
                for (int g = 0; g < 16; g++) if (gl[g] == lit) gv = g;
                if (lit == 7'h00 || gv >= 0) begin
                    e_digits[idx]    = (gv >= 0) ? 4'(gv) : 4'd0;
                    e_blank[idx]     = (gv < 0);
                    e_dots[idx]      = ~last_in[7];
                    e_committed[idx] = 1'b1;
                    e_last[idx]      = cyc;
                    cm[idx]          = 1'b1;
                end else begin
                    e_bad = 1'b1;
                end
            end
        end
        e_frame = (e_seen == 8'hFF);
        e_seen  = (e_frame ? 8'h00 : e_seen) | cm;
        if (v == last_in) begin
            if (run < 1000) run++;
        end else begin
            last_in = v;
            run     = 1;
        end
    endtask

    function automatic logic [7:0] exp_valid();
        logic [7:0] r;
        r = e_committed;
`ifdef SEG_SCAN_TIMEOUT_EN
        for (int i = 0; i < 8; i++) if (cyc - e_last[i] >= TO) r[i] = 1'b0;
`endif
        return r;
    endfunction

    task automatic check_all();
        chk("digits",      32'(digits),      32'(e_digits));
        chk("dots",        32'(dots),        32'(e_dots));
        chk("blank",       32'(blank),       32'(e_blank));
        chk("valid",       32'(valid),       32'(exp_valid()));
        chk("frame_done",  32'(frame_done),  32'(e_frame));
        chk("bad_pattern", 32'(bad_pattern), 32'(e_bad));
        chk("multi_sel",   32'(multi_sel),   32'(e_multi));
        if (frame_done === 1'b1)  n_frame++;
        if (bad_pattern === 1'b1) n_bad++;
        if (multi_sel === 1'b1)   n_multi++;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_digits"}, 32'(digits), 32'h0);
        chk({tag, "_dots"},   32'(dots),   32'h0);
        chk({tag, "_blank"},  32'(blank),  32'h0);
        chk({tag, "_valid"},  32'(valid),  32'h0);
        chk({tag, "_frame"},  32'(frame_done),  32'h0);
        chk({tag, "_bad"},    32'(bad_pattern), 32'h0);
        chk({tag, "_multi"},  32'(multi_sel),   32'h0);
    endtask

    task automatic tick(input logic [7:0] en, input logic [7:0] seg);
        scan_en  = en;
        scan_seg = seg;
        @(posedge clock);
        model_edge({en, seg});
        #1;
        check_all();
    endtask

    function automatic logic [7:0] sel_dig(input int d);
        return ~(8'd1 << d);
    endfunction

    function automatic logic [7:0] seg_of(input int g, input logic dp_lit);
        return {~dp_lit, ~gl[g]};
    endfunction

    task automatic async_reset();
        #2;
        rst = 1'b0;
        #1;
        check_zero("async_rst");
        model_reset();
        repeat (2) @(posedge clock);
        #2;
        rst = 1'b1;
    endtask

    initial begin
        logic [7:0] en, seg;
        int         hold, k, a, b;
        model_reset();
        cyc = 0;
        n_frame = 0;
        n_bad   = 0;
        n_multi = 0;

        #1;
        check_zero("reset");
        repeat (2) @(posedge clock);
        #2;
        rst = 1'b1;
        repeat (2) tick(8'hFF, 8'hFF);

        // Single digit: '0' on digit 2, dp off
        repeat (4) tick(8'hFB, 8'hC0);
        chk("single_not_yet", 32'(valid), 32'h0);
        tick(8'hFB, 8'hC0);
        chk("single_digit2", 32'(digits[2]), 32'h0);
        chk("single_dot2",   32'(dots[2]),   32'h0);
        chk("single_valid",  32'(valid),     32'h04);
        repeat (2) tick(8'hFF, 8'hFF);

        // Full scan: digits 0..7 show 1..8, dp on digit 7
        n_frame = 0;
        for (int d = 0; d < 8; d++)
            repeat (6) tick(sel_dig(d), seg_of(d + 1, d == 7));
        repeat (3) tick(8'hFF, 8'hFF);
        chk("scan_digits", 32'(digits), 32'h87654321);
        chk("scan_dots",   32'(dots),   32'h80);
        chk("scan_frames", 32'(n_frame), 32'd1);

        // Glitch filter on digit 3
        n_bad = 0;
        n_multi = 0;
        for (int r = 0; r < 4; r++)
            repeat (3) tick(sel_dig(3), seg_of((r % 2 == 0) ? 5 : 6, 1'b0));
        chk("glitch_hold", 32'(digits[3]), 32'h4);
        repeat (4) tick(sel_dig(3), seg_of(9, 1'b0));
        tick(8'hFF, 8'hFF);
        chk("glitch_commit", 32'(digits[3]), 32'h9);
        chk("glitch_pulses", 32'(n_bad + n_multi), 32'd0);

        // Faults
        n_multi = 0;
        repeat (6) tick(8'hF0, 8'hC0);
        chk("multi_once", 32'(n_multi), 32'd1);
        n_bad = 0;
        repeat (6) tick(8'hFE, 8'hFE);
        chk("bad_once", 32'(n_bad), 32'd1);

        // Blank on digit 0
        repeat (5) tick(8'hFE, 8'hFF);
        chk("blank0", 32'(blank[0]), 32'h1);
        chk("valid0", 32'(valid[0]), 32'h1);

        // Reset mid-window, then a fresh full window is required
        repeat (2) tick(8'hFD, seg_of(10, 1'b0));
        async_reset();
        repeat (4) tick(8'hFD, seg_of(10, 1'b0));
        chk("rst_no_early", 32'(valid), 32'h0);
        tick(8'hFD, seg_of(10, 1'b0));
        chk("rst_recommit",  32'(valid),     32'h02);
        chk("rst_digit1",    32'(digits[1]), 32'hA);

`ifdef SEG_SCAN_TIMEOUT_EN
        repeat (2) tick(8'hFF, 8'hFF);
        repeat (5) tick(sel_dig(5), seg_of(7, 1'b0));
        repeat (15) tick(8'hFF, 8'hFF);
        chk("to_still_valid", 32'(valid[5]), 32'h1);
        tick(8'hFF, 8'hFF);
        chk("to_dropped",  32'(valid[5]),  32'h0);
        chk("to_retained", 32'(digits[5]), 32'h7);
`endif

        // Random scan traffic
        for (int t = 0; t < 300; t++) begin
            k = $urandom_range(0, 9);
            if (k < 7) begin
                en = sel_dig($urandom_range(0, 7));
            end else if (k == 7) begin
                en = 8'hFF;
            end else begin
                a  = $urandom_range(0, 7);
                b  = (a + $urandom_range(1, 7)) % 8;
                en = ~((8'd1 << a) | (8'd1 << b));
            end
            k = $urandom_range(0, 9);
            if (k < 7)
                seg = seg_of($urandom_range(0, 15), 1'($urandom_range(0, 1)));
            else if (k == 7)
                seg = {1'($urandom_range(0, 1)), 7'h7F};
            else
                seg = 8'($urandom);
            hold = $urandom_range(1, 7);
            repeat (hold) tick(en, seg);
        end
        repeat (6) tick(8'hFF, 8'hFF);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
